// File: rtl/mem_arbiter_if.sv
// Signal bundle between mem_arbiter, the core's fetch/data ports and the shared memory.
// slave = arbiter side, master = core plus memory side.
interface mem_arbiter_if;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = 4;

    logic              i_if_req;
    logic [ADDR_W-1:0] i_if_addr;
    logic              i_if_flush;
    logic              o_if_gnt;
    logic              o_if_ack;
    logic [DATA_W-1:0] o_if_data;

    logic              i_d_req;
    logic [ADDR_W-1:0] i_d_addr;
    logic [STRB_W-1:0] i_d_we;
    logic [DATA_W-1:0] i_d_wdata;
    logic              o_d_gnt;
    logic              o_d_ack;
    logic [DATA_W-1:0] o_d_rdata;

    logic              o_mem_en;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [STRB_W-1:0] o_mem_we;
    logic [DATA_W-1:0] o_mem_wdata;
    logic [DATA_W-1:0] i_mem_rdata;

    modport slave (
        input  i_if_req, i_if_addr, i_if_flush,
        output o_if_gnt, o_if_ack, o_if_data,
        input  i_d_req, i_d_addr, i_d_we, i_d_wdata,
        output o_d_gnt, o_d_ack, o_d_rdata,
        output o_mem_en, o_mem_addr, o_mem_we, o_mem_wdata,
        input  i_mem_rdata
    );

    modport master (
        output i_if_req, i_if_addr, i_if_flush,
        input  o_if_gnt, o_if_ack, o_if_data,
        output i_d_req, i_d_addr, i_d_we, i_d_wdata,
        input  o_d_gnt, o_d_ack, o_d_rdata,
        input  o_mem_en, o_mem_addr, o_mem_we, o_mem_wdata,
        output i_mem_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one single-port synchronous memory between instruction fetch and load/store.
// Optional macro ARB_RR_EN: alternate grants on contested cycles instead of strict data priority.
module mem_arbiter (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_clk_ce,
    mem_arbiter_if.slave bus
);
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = 4;
    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

    typedef enum logic [1:0] {
        PEND_NONE = 2'd0,
        PEND_IF   = 2'd1,
        PEND_D    = 2'd2,
        PEND_DW   = 2'd3
    } pend_t;

    pend_t r_pend;
    pend_t w_pend_nxt;

    logic w_run;
    logic w_if_cand;
    logic w_d_cand;
    logic w_d_gnt;
    logic w_if_gnt;
    logic w_if_ack;
    logic w_d_ack;

    // Reset kills grants and acks in the same cycle so an in-flight access is dropped.
    assign w_run     = i_clk_ce && !i_rst;
    assign w_if_cand = w_run && bus.i_if_req && !bus.i_if_flush;
    assign w_d_cand  = w_run && bus.i_d_req;

`ifdef ARB_RR_EN
    logic r_rr_if;
    logic w_contested;

    assign w_contested = w_if_cand && w_d_cand;
    assign w_d_gnt     = w_d_cand && !(w_contested && r_rr_if);

    // Fairness pointer: 0 favours data, flips on every contested grant.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rr_if <= 1'b0;
        end else if (w_contested) begin
            r_rr_if <= !r_rr_if;
        end
    end
`else
    assign w_d_gnt = w_d_cand;
`endif

    assign w_if_gnt = w_if_cand && !w_d_gnt;

    always_comb begin
        w_pend_nxt = PEND_NONE;
        if (w_d_gnt) begin
            if (bus.i_d_we == '0) begin
                w_pend_nxt = PEND_D;
            end else begin
                w_pend_nxt = PEND_DW;
            end
        end else if (w_if_gnt) begin
            w_pend_nxt = PEND_IF;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pend <= PEND_NONE;
        end else if (i_clk_ce) begin
            r_pend <= w_pend_nxt;
        end
    end

    // Command path follows the granted requester; idle bus is all zeros.
    always_comb begin
        bus.o_mem_addr  = '0;
        bus.o_mem_we    = '0;
        bus.o_mem_wdata = '0;
        if (w_d_gnt) begin
            bus.o_mem_addr  = bus.i_d_addr & WORD_MASK;
            bus.o_mem_we    = bus.i_d_we;
            bus.o_mem_wdata = bus.i_d_wdata;
        end else if (w_if_gnt) begin
            bus.o_mem_addr  = bus.i_if_addr & WORD_MASK;
        end
    end

    assign bus.o_mem_en = w_d_gnt || w_if_gnt;
    assign bus.o_d_gnt  = w_d_gnt;
    assign bus.o_if_gnt = w_if_gnt;

    assign w_if_ack = w_run && (r_pend == PEND_IF) && !bus.i_if_flush;
    assign w_d_ack  = w_run && ((r_pend == PEND_D) || (r_pend == PEND_DW));

    assign bus.o_if_ack  = w_if_ack;
    assign bus.o_d_ack   = w_d_ack;
    assign bus.o_if_data = w_if_ack ? bus.i_mem_rdata : DATA_W'(0);
    assign bus.o_d_rdata = (w_d_ack && (r_pend == PEND_D)) ? bus.i_mem_rdata : DATA_W'(0);

    logic [STRB_W-1:0] w_unused_strb;
    assign w_unused_strb = '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios then random traffic against a reference model.
module tb_mem_arbiter;
    localparam int unsigned MEM_WORDS = 256;
    localparam int K_NONE = 0;
    localparam int K_IF   = 1;
    localparam int K_DR   = 2;
    localparam int K_DW   = 3;

    logic clk = 1'b0;
    logic rst;
    logic ce;

    mem_arbiter_if bus();

    mem_arbiter dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_clk_ce (ce),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        return (32'(i) * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
    endfunction

    // Environment memory: one-cycle read latency, read data held while not enabled.
    logic [31:0] env_mem [MEM_WORDS];
    logic [31:0] r_mem_rdata = '0;
    logic        env_loaded  = 1'b0;
    assign bus.i_mem_rdata = r_mem_rdata;

    always @(posedge clk) begin
        if (!env_loaded) begin
            for (int i = 0; i < int'(MEM_WORDS); i++) env_mem[i] <= init_word(i);
            env_loaded <= 1'b1;
        end else if (bus.o_mem_en) begin
            for (int b = 0; b < 4; b++)
                if (bus.o_mem_we[b]) env_mem[bus.o_mem_addr[9:2]][8*b +: 8] <= bus.o_mem_wdata[8*b +: 8];
            r_mem_rdata <= env_mem[bus.o_mem_addr[9:2]];
        end
    end

    // Reference model state
    logic [31:0] ref_mem [MEM_WORDS];
    int          m_kind = K_NONE;
    logic [31:0] m_exp  = '0;
`ifdef ARB_RR_EN
    logic        m_turn_if = 1'b0;
`endif

    logic        e_ignt, e_dgnt, e_ifack, e_dack, e_en;
    logic [31:0] e_ifdata, e_drdata, e_addr, e_wdata;
    logic [3:0]  e_we;
    logic        obs_ignt, obs_dgnt, obs_ifack, obs_dack, obs_en;
    logic [31:0] obs_ifdata, obs_drdata;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: predict, compare at negedge, advance the model at posedge.
    task automatic step();
        logic run, ifc, dc;
        int   idx;
        run = ce && !rst;
        ifc = run && bus.i_if_req && !bus.i_if_flush;
        dc  = run && bus.i_d_req;
`ifdef ARB_RR_EN
        e_dgnt = dc && !(ifc && dc && m_turn_if);
`else
        e_dgnt = dc;
`endif
        e_ignt   = ifc && !e_dgnt;
        e_en     = e_dgnt || e_ignt;
        e_ifack  = run && (m_kind == K_IF) && !bus.i_if_flush;
        e_dack   = run && (m_kind == K_DR || m_kind == K_DW);
        e_ifdata = e_ifack ? m_exp : 32'h0;
        e_drdata = (e_dack && m_kind == K_DR) ? m_exp : 32'h0;
        e_addr   = e_dgnt ? {bus.i_d_addr[31:2], 2'b00} : e_ignt ? {bus.i_if_addr[31:2], 2'b00} : 32'h0;
        e_we     = e_dgnt ? bus.i_d_we : 4'h0;
        e_wdata  = e_dgnt ? bus.i_d_wdata : 32'h0;

        @(negedge clk);
        obs_ignt   = bus.o_if_gnt;
        obs_dgnt   = bus.o_d_gnt;
        obs_ifack  = bus.o_if_ack;
        obs_dack   = bus.o_d_ack;
        obs_en     = bus.o_mem_en;
        obs_ifdata = bus.o_if_data;
        obs_drdata = bus.o_d_rdata;
        check("if_gnt",    32'(obs_ignt),   32'(e_ignt));
        check("d_gnt",     32'(obs_dgnt),   32'(e_dgnt));
        check("if_ack",    32'(obs_ifack),  32'(e_ifack));
        check("d_ack",     32'(obs_dack),   32'(e_dack));
        check("if_data",   obs_ifdata,      e_ifdata);
        check("d_rdata",   obs_drdata,      e_drdata);
        check("mem_en",    32'(obs_en),     32'(e_en));
        check("mem_addr",  bus.o_mem_addr,  e_addr);
        check("mem_we",    32'(bus.o_mem_we), 32'(e_we));
        check("mem_wdata", bus.o_mem_wdata, e_wdata);

        @(posedge clk);
        if (rst) begin
            m_kind = K_NONE;
`ifdef ARB_RR_EN
            m_turn_if = 1'b0;
`endif
        end else if (ce) begin
`ifdef ARB_RR_EN
            if (ifc && dc) m_turn_if = !m_turn_if;
`endif
            idx = int'(e_addr[9:2]);
            if (e_dgnt && e_we != 4'h0) begin
                m_kind = K_DW;
                for (int b = 0; b < 4; b++)
                    if (e_we[b]) ref_mem[idx][8*b +: 8] = e_wdata[8*b +: 8];
            end else if (e_dgnt) begin
                m_kind = K_DR;
                m_exp  = ref_mem[idx];
            end else if (e_ignt) begin
                m_kind = K_IF;
                m_exp  = ref_mem[idx];
            end else begin
                m_kind = K_NONE;
            end
        end
        #1;
    endtask

    initial begin
        logic [2:0] seq;
        logic [2:0] seq_exp;
        logic       if_hold;
        logic       d_hold;

        for (int i = 0; i < int'(MEM_WORDS); i++) ref_mem[i] = init_word(i);
        rst = 1'b1; ce = 1'b1;
        bus.i_if_req = 1'b0; bus.i_if_addr = '0; bus.i_if_flush = 1'b0;
        bus.i_d_req = 1'b0; bus.i_d_addr = '0; bus.i_d_we = '0; bus.i_d_wdata = '0;
        step(); step();
        rst = 1'b0;
        step();
        check("post_rst_en", 32'(obs_en), 32'h0);

        // Back-to-back fetches
        bus.i_if_req = 1'b1; bus.i_if_addr = 32'h100;
        step();
        check("f0_gnt", 32'(obs_ignt), 32'h1);
        bus.i_if_addr = 32'h104;
        step();
        check("f1_gnt", 32'(obs_ignt), 32'h1);
        check("f0_data", obs_ifdata, init_word(64));
        bus.i_if_req = 1'b0;
        step();
        check("f1_data", obs_ifdata, init_word(65));

        // Write then read back
        bus.i_d_req = 1'b1; bus.i_d_addr = 32'h20; bus.i_d_we = 4'hF; bus.i_d_wdata = 32'hDEADBEEF;
        step();
        bus.i_d_we = 4'h0; bus.i_d_wdata = 32'h0;
        step();
        check("wr_ack", 32'(obs_dack), 32'h1);
        check("wr_ack_rdata", obs_drdata, 32'h0);
        bus.i_d_req = 1'b0;
        step();
        check("rd_data", obs_drdata, 32'hDEADBEEF);

        // Contested requests for three cycles
        bus.i_if_req = 1'b1; bus.i_if_addr = 32'h200;
        bus.i_d_req = 1'b1; bus.i_d_addr = 32'h40;
        for (int i = 0; i < 3; i++) begin
            step();
            seq[i] = obs_dgnt;
        end
`ifdef ARB_RR_EN
        seq_exp = 3'b101;
`else
        seq_exp = 3'b111;
`endif
        check("contest_seq", 32'(seq), 32'(seq_exp));
        bus.i_d_req = 1'b0;
        step();
        bus.i_if_req = 1'b0;
        step(); step();

        // Flush kills in-flight fetch ack and blocks the grant
        bus.i_if_req = 1'b1; bus.i_if_addr = 32'h300;
        step();
        bus.i_if_flush = 1'b1;
        step();
        check("flush_ack", 32'(obs_ifack), 32'h0);
        check("flush_gnt", 32'(obs_ignt), 32'h0);
        bus.i_if_flush = 1'b0;
        step();
        check("resume_gnt", 32'(obs_ignt), 32'h1);
        bus.i_if_req = 1'b0;
        step(); step();

        // Clock enable low between grant and ack
        bus.i_d_req = 1'b1; bus.i_d_addr = 32'h20;
        step();
        bus.i_d_req = 1'b0; ce = 1'b0;
        step();
        check("ce_lo_ack0", 32'(obs_dack), 32'h0);
        step();
        check("ce_lo_ack1", 32'(obs_dack), 32'h0);
        ce = 1'b1;
        step();
        check("ce_ack", 32'(obs_dack), 32'h1);
        check("ce_data", obs_drdata, 32'hDEADBEEF);

        // Reset right after a data grant drops the access
        bus.i_d_req = 1'b1; bus.i_d_addr = 32'h24;
        step();
        bus.i_d_req = 1'b0; rst = 1'b1;
        step();
        check("rst_no_ack0", 32'(obs_dack), 32'h0);
        rst = 1'b0;
        step();
        check("rst_no_ack1", 32'(obs_dack), 32'h0);
        check("rst_mem_en", 32'(obs_en), 32'h0);

        // Random traffic; requests stay stable until granted
        if_hold = 1'b0;
        d_hold  = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 99) == 0);
            ce  = ($urandom_range(0, 99) < 85);
            bus.i_if_flush = ($urandom_range(0, 9) == 0);
            if (!if_hold) begin
                bus.i_if_req  = ($urandom_range(0, 99) < 60);
                bus.i_if_addr = 32'($urandom_range(0, 1023));
            end
            if (!d_hold) begin
                bus.i_d_req   = ($urandom_range(0, 99) < 40);
                bus.i_d_addr  = 32'($urandom_range(0, 1023));
                bus.i_d_we    = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
                bus.i_d_wdata = $urandom;
            end
            step();
            if_hold = bus.i_if_req && !e_ignt && !rst;
            d_hold  = bus.i_d_req && !e_dgnt && !rst;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
